// File: rtl/interval_meter.sv
// Start/stop interval meter: counts clk cycles between a start and a stop pulse and
// presents the result over a valid/ready handshake. INTERVAL_METER_DROP_CNT_EN adds drop_cnt.
//
//   state | meaning
//   IDLE  | waiting for start; stop and res_ready ignored
//   COUNT | counting cycles until stop; start ignored
//   DONE  | result held on res_data/res_sat until res_ready
module interval_meter #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_sat,
`ifdef INTERVAL_METER_DROP_CNT_EN
    output logic [7:0]       drop_cnt,
`endif
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state;
    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_sat   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= COUNT;
                        cnt   <= CNT_ONE;
                        busy  <= 1'b1;
                    end
                end
                COUNT: begin
                    if (stop) begin
                        state     <= DONE;
                        res_data  <= cnt;
                        res_sat   <= (cnt == CNT_MAX);
                        res_valid <= 1'b1;
                        busy      <= 1'b0;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                DONE: begin
                    // res_data/res_sat keep their last value after the handshake
                    if (res_ready) begin
                        state     <= IDLE;
                        res_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

`ifdef INTERVAL_METER_DROP_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= 8'd0;
        end else if (start && (state != IDLE) && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_interval_meter.sv
// Directed self-checking bench for interval_meter (WIDTH=10); covers drop_cnt when
// INTERVAL_METER_DROP_CNT_EN is defined.
module tb_interval_meter;

    localparam int WIDTH = 10;

    logic             clk;
    logic             rst;
    logic             start;
    logic             stop;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_sat;
    logic             busy;
`ifdef INTERVAL_METER_DROP_CNT_EN
    logic [7:0]       drop_cnt;
    int               exp_drop;
`endif

    int chk_cnt;
    int pass_cnt;

    interval_meter #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_sat   (res_sat),
`ifdef INTERVAL_METER_DROP_CNT_EN
        .drop_cnt  (drop_cnt),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance past one rising edge; inputs are driven and outputs sampled 1ns later
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0; res_ready = 1'b1;
        cyc();
        cyc();
        chk_cnt++;
        if ({res_valid, res_data, res_sat, busy} !== {1'b0, 10'd0, 1'b0, 1'b0})
            $display("FAIL reset_outputs: got v=%0b d=%0d s=%0b b=%0b want all 0",
                     res_valid, res_data, res_sat, busy);
        else pass_cnt++;
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_basic();
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk_cnt++;
        if (busy !== 1'b1) $display("FAIL basic_busy: got %0b want 1", busy);
        else pass_cnt++;
        repeat (4) cyc();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk_cnt++;
        if ({res_valid, res_data, res_sat, busy} !== {1'b1, 10'd5, 1'b0, 1'b0})
            $display("FAIL basic_result: got v=%0b d=%0d s=%0b b=%0b want v=1 d=5 s=0 b=0",
                     res_valid, res_data, res_sat, busy);
        else pass_cnt++;
        cyc();
        chk_cnt++;
        if ({res_valid, busy} !== 2'b00)
            $display("FAIL basic_idle: got v=%0b b=%0b want 0 0", res_valid, busy);
        else pass_cnt++;
    endtask

    task automatic test_saturation();
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (1499) cyc();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk_cnt++;
        if ({res_valid, res_data, res_sat} !== {1'b1, 10'd1023, 1'b1})
            $display("FAIL sat_result: got v=%0b d=%0d s=%0b want v=1 d=1023 s=1",
                     res_valid, res_data, res_sat);
        else pass_cnt++;
        cyc();
        chk_cnt++;
        if (res_valid !== 1'b0) $display("FAIL sat_handshake: got v=%0b want 0", res_valid);
        else pass_cnt++;
    endtask

    task automatic test_same_cycle();
        start = 1'b1; stop = 1'b1;
        cyc();
        start = 1'b0; stop = 1'b0;
        chk_cnt++;
        if ({busy, res_valid} !== 2'b10)
            $display("FAIL same_cycle_state: got b=%0b v=%0b want b=1 v=0", busy, res_valid);
        else pass_cnt++;
        repeat (2) cyc();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk_cnt++;
        if ({res_valid, res_data, res_sat} !== {1'b1, 10'd3, 1'b0})
            $display("FAIL same_cycle_result: got v=%0b d=%0d s=%0b want v=1 d=3 s=0",
                     res_valid, res_data, res_sat);
        else pass_cnt++;
        cyc();
    endtask

    task automatic test_ignored();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk_cnt++;
        if ({busy, res_valid} !== 2'b00)
            $display("FAIL idle_stop: got b=%0b v=%0b want 0 0", busy, res_valid);
        else pass_cnt++;
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (2) cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
`ifdef INTERVAL_METER_DROP_CNT_EN
        exp_drop++;
`endif
        cyc();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk_cnt++;
        if ({res_valid, res_data, res_sat} !== {1'b1, 10'd5, 1'b0})
            $display("FAIL count_start_ignored: got v=%0b d=%0d s=%0b want v=1 d=5 s=0",
                     res_valid, res_data, res_sat);
        else pass_cnt++;
        cyc();
    endtask

    task automatic test_hold();
        int bad;
        res_ready = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (6) cyc();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            start = (i % 2 == 0);
            stop  = (i % 2 == 1);
`ifdef INTERVAL_METER_DROP_CNT_EN
            if (i % 2 == 0) exp_drop++;
`endif
            cyc();
            chk_cnt++;
            if ({res_valid, res_data, res_sat, busy} !== {1'b1, 10'd7, 1'b0, 1'b0}) begin
                if (bad == 0)
                    $display("FAIL hold_stable[%0d]: got v=%0b d=%0d s=%0b b=%0b want v=1 d=7 s=0 b=0",
                             i, res_valid, res_data, res_sat, busy);
                bad++;
            end else pass_cnt++;
        end
        start = 1'b1; stop = 1'b0; res_ready = 1'b1;
        cyc();
        start = 1'b0;
`ifdef INTERVAL_METER_DROP_CNT_EN
        exp_drop++;
`endif
        chk_cnt++;
        if ({res_valid, busy} !== 2'b00)
            $display("FAIL handshake_no_bypass: got v=%0b b=%0b want 0 0", res_valid, busy);
        else pass_cnt++;
`ifdef INTERVAL_METER_DROP_CNT_EN
        chk_cnt++;
        if (drop_cnt !== exp_drop[7:0])
            $display("FAIL drop_cnt: got %0d want %0d", drop_cnt, exp_drop);
        else pass_cnt++;
`endif
    endtask

    task automatic test_rst_mid();
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (3) cyc();
        #2;
        rst = 1'b1;
        #1;
        chk_cnt++;
        if ({res_valid, res_data, res_sat, busy} !== {1'b0, 10'd0, 1'b0, 1'b0})
            $display("FAIL rst_count_async: got v=%0b d=%0d s=%0b b=%0b want all 0",
                     res_valid, res_data, res_sat, busy);
        else pass_cnt++;
`ifdef INTERVAL_METER_DROP_CNT_EN
        exp_drop = 0;
        chk_cnt++;
        if (drop_cnt !== 8'd0) $display("FAIL drop_cnt_rst: got %0d want 0", drop_cnt);
        else pass_cnt++;
`endif
        #1;
        rst = 1'b0;
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        repeat (2) cyc();
        chk_cnt++;
        if ({res_valid, busy} !== 2'b00)
            $display("FAIL rst_no_result: got v=%0b b=%0b want 0 0", res_valid, busy);
        else pass_cnt++;

        // reset while a result is waiting
        res_ready = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk_cnt++;
        if ({res_valid, res_data} !== {1'b1, 10'd1})
            $display("FAIL min_interval: got v=%0b d=%0d want v=1 d=1", res_valid, res_data);
        else pass_cnt++;
        #2;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        repeat (2) cyc();
        chk_cnt++;
        if ({res_valid, res_data} !== {1'b0, 10'd0})
            $display("FAIL rst_done_discard: got v=%0b d=%0d want v=0 d=0", res_valid, res_data);
        else pass_cnt++;

        res_ready = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk_cnt++;
        if ({res_valid, res_data, res_sat} !== {1'b1, 10'd2, 1'b0})
            $display("FAIL after_rst_measure: got v=%0b d=%0d s=%0b want v=1 d=2 s=0",
                     res_valid, res_data, res_sat);
        else pass_cnt++;
        cyc();
    endtask

    initial begin
        chk_cnt = 0;
        pass_cnt = 0;
`ifdef INTERVAL_METER_DROP_CNT_EN
        exp_drop = 0;
`endif
        rst = 1'b1; start = 1'b0; stop = 1'b0; res_ready = 1'b1;
        test_reset();
        test_basic();
        test_saturation();
        test_same_cycle();
        test_ignored();
        test_hold();
        test_rst_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/interval_meter.md
INTERVAL_METER -- requirements
Module: interval_meter

Interface
REQ-001 Parameter WIDTH, default 10: width of measured interval and result.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  single-cycle pulse marking interval begin.
REQ-005 stop  input  1  single-cycle pulse marking interval end.
REQ-006 res_valid  output  1  measured result available.
REQ-007 res_ready  input  1  consumer accepts result.
REQ-008 res_data  output  WIDTH  measured interval in clk cycles.
REQ-009 res_sat  output  1  interval reached the saturation limit.
REQ-010 busy  output  1  high while in COUNT state.

Function
REQ-011 The FSM SHALL have three states: IDLE, COUNT and DONE.
REQ-012 IDLE: start=1 SHALL move to COUNT and load the internal counter with 1; stop in IDLE SHALL be ignored.
REQ-013 start=1 and stop=1 in the same IDLE cycle SHALL be treated as start only.
REQ-014 COUNT: each cycle with stop=0, the counter SHALL increment by 1, saturating at 2^WIDTH-1 (no wrap).
REQ-015 COUNT: stop=1 SHALL capture the counter into res_data, set res_sat = (counter == 2^WIDTH-1), and move to DONE.
REQ-016 For start at edge t and stop at edge t+N (N>=1), res_data SHALL equal min(N, 2^WIDTH-1).
REQ-017 start in COUNT SHALL be ignored; the measurement does not restart.
REQ-018 res_valid SHALL be high exactly while in DONE; it rises the cycle after stop is sampled.
REQ-019 res_data and res_sat SHALL stay stable while res_valid=1 and res_ready=0.
REQ-020 DONE: res_valid=1 and res_ready=1 at an edge SHALL complete the handshake and move to IDLE.
REQ-021 start and stop in DONE SHALL be ignored, including in the handshake cycle; no back-to-back bypass.
REQ-022 busy SHALL be high in COUNT only; res_ready SHALL have no effect outside DONE.

Reset
REQ-023 rst=1 SHALL immediately force IDLE, counter=0, res_valid=0, res_data=0, res_sat=0 and busy=0, independent of clk.
REQ-024 rst asserted mid-COUNT or mid-DONE SHALL discard the measurement; no result is presented after release.
REQ-025 After rst deasserts, the first start on a rising edge SHALL be accepted normally.

Configuration
REQ-026 Macro INTERVAL_METER_DROP_CNT_EN defined: add output drop_cnt [7:0]. It SHALL increment, saturating at 255, on each start=1 ignored in COUNT or DONE. It SHALL be cleared by rst.
REQ-027 Macro INTERVAL_METER_DROP_CNT_EN undefined: port drop_cnt and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-028 start at cycle 0, stop at cycle 5, res_ready=1 -> res_valid=1 at cycle 6 with res_data=5 and res_sat=0; IDLE at cycle 7.
REQ-029 start, then stop after 1500 cycles (WIDTH=10) -> res_data=1023, res_sat=1.
REQ-030 res_ready held 0 for 20 cycles after a result, with start/stop pulses toggled meanwhile -> res_data stable and no new measurement; drop_cnt counts the starts when the macro is enabled.
REQ-031 start and stop in the same IDLE cycle, then stop 3 cycles later -> res_data=3.
REQ-032 rst pulsed between clock edges mid-COUNT -> outputs zero immediately; a following stop produces no res_valid.
REQ-033 stop in IDLE, start in COUNT -> both ignored; the original interval is reported unchanged.
